// File: rtl/pc_pkg.sv
// pc_pkg: shared select/state encodings for the program-counter fetch unit.
package pc_pkg;
   typedef enum logic [1:0] {SEL_SEQ = 2'b00, SEL_JMP = 2'b01, SEL_RSV = 2'b10, SEL_BR = 2'b11} next_sel_t;
   typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} fetch_state_t;
   function automatic logic is_redirect(input next_sel_t s);
      return s == SEL_JMP || s == SEL_BR;
   endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc,instr} holding register for decode back-pressure.
module fetch_skid_buf #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               clear,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               valid,
   output logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] instr
);
   always_ff @(posedge clk) begin
      if (rst) valid <= 1'b0;
      else valid <= !clear & (load | valid);
      if (load) begin
         pc    <= pc_in;
         instr <= instr_in;
      end
   end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, redirect mux and fetch FSM feeding decode through a 1-entry skid.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_INC   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               resolve_valid,
   input  logic [1:0]         next_instr_sel,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               instr_valid,
   input  logic               instr_ready
);
   fetch_state_t       state, state_nx;
   next_sel_t          sel;
   logic [ADDR_W-1:0]  fetch_pc, inflight_pc, target, skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic               inflight_v, skid_v, redirect, stall, issue, capture, skid_clr;
   assign sel      = next_sel_t'(next_instr_sel);
   assign redirect = resolve_valid & is_redirect(sel);
   assign target   = sel == SEL_BR ? branch_target : jump_target;
   assign stall    = inflight_v & !instr_ready;
   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = redirect ? FLUSH :
                 (state == BOOT || state == FLUSH) ? RUN :
                 state == RUN ? (stall ? HOLD : RUN) :
                 (instr_ready ? RUN : HOLD);
   end
   // A stalled RUN parks the returning word in the skid and stops issuing until it drains.
   always_comb begin
      issue    = !redirect && state != HOLD && !(state == RUN && stall);
      capture  = !redirect && state == RUN && stall;
      skid_clr = redirect || (state == HOLD && instr_ready);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= RESET_PC;
         inflight_v  <= 1'b0;
      end else begin
         fetch_pc   <= redirect ? target : issue ? fetch_pc + ADDR_W'(PC_INC) : fetch_pc;
         inflight_v <= issue;
         if (issue) inflight_pc <= fetch_pc;
      end
   end
   fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (capture),
      .clear    (skid_clr),
      .pc_in    (inflight_pc),
      .instr_in (imem_rdata),
      .valid    (skid_v),
      .pc       (skid_pc),
      .instr    (skid_instr)
   );
   assign imem_addr   = fetch_pc;
   assign instr_valid = (skid_v | inflight_v) & !redirect;
   assign pc_out      = skid_v ? skid_pc : inflight_pc;
   assign instr_out   = skid_v ? skid_instr : imem_rdata;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table, corner sequences and a randomized stream scoreboard.
module tb_pc_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        resolve_valid = 1'b0;
   logic [1:0]  next_instr_sel = 2'b00;
   logic [31:0] jump_target = '0, branch_target = '0;
   logic [31:0] imem_addr, imem_rdata = '0, instr_out, pc_out;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   int checks = 0, errors = 0;

   pc_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .resolve_valid  (resolve_valid),
      .next_instr_sel (next_instr_sel),
      .jump_target    (jump_target),
      .branch_target  (branch_target),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   always @(posedge clk) imem_rdata <= memf(imem_addr);

   typedef struct {
      logic        rv;
      logic [1:0]  sel;
      logic [31:0] jt, bt;
      logic        rdy, ev;
      logic [31:0] epc, eaddr;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic rv, input logic [1:0] sel, input logic [31:0] tgt,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [31:0] eaddr);
      vec_t v;
      v.rv = rv; v.sel = sel; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
      v.jt = sel[1] ? tgt ^ 32'h800 : tgt;
      v.bt = sel[1] ? tgt : tgt ^ 32'h800;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic rv, input logic [1:0] sel,
                        input logic [31:0] jt, input logic [31:0] bt, input logic rdy);
      rst = r; resolve_valid = rv; next_instr_sel = sel;
      jump_target = jt; branch_target = bt; instr_ready = rdy;
      @(negedge clk);
   endtask

   logic [31:0] exp_pc, tgt;
   logic        redir, prev_redir, prev_stall;
   int          quiet;

   initial begin
      repeat (3) tick();
      tbl.push_back(mk(0, 2'd0, 0,      1, 0, 0,      32'h0));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h0,  32'h4));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h4,  32'h8));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h8,  32'hC));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'hC,  32'h10));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 2'd0, 0, 0, 1, 32'h10, 32'h14));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h10, 32'h14));
      tbl.push_back(mk(0, 2'd0, 0,      1, 0, 0,      32'h14));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h14, 32'h18));
      tbl.push_back(mk(1, 2'd3, 32'h100, 1, 0, 0,     32'h1C));
      tbl.push_back(mk(0, 2'd0, 0,      1, 0, 0,      32'h100));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h100, 32'h104));
      tbl.push_back(mk(1, 2'd2, 32'h200, 1, 1, 32'h104, 32'h108));
      tbl.push_back(mk(1, 2'd0, 32'h200, 1, 1, 32'h108, 32'h10C));
      tbl.push_back(mk(0, 2'd0, 0,      0, 1, 32'h10C, 32'h110));
      tbl.push_back(mk(0, 2'd0, 0,      0, 1, 32'h10C, 32'h110));
      tbl.push_back(mk(1, 2'd1, 32'h40, 0, 0, 0,      32'h110));
      tbl.push_back(mk(0, 2'd0, 0,      0, 0, 0,      32'h40));
      tbl.push_back(mk(0, 2'd0, 0,      0, 1, 32'h40, 32'h44));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h40, 32'h44));
      tbl.push_back(mk(0, 2'd0, 0,      1, 0, 0,      32'h44));
      tbl.push_back(mk(0, 2'd0, 0,      1, 1, 32'h44, 32'h48));
      foreach (tbl[i]) begin
         drive(1'b0, tbl[i].rv, tbl[i].sel, tbl[i].jt, tbl[i].bt, tbl[i].rdy);
         chk($sformatf("vec%0d_valid", i), instr_valid, tbl[i].ev);
         chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].eaddr);
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_pc", i), pc_out, tbl[i].epc);
            chk($sformatf("vec%0d_instr", i), instr_out, memf(tbl[i].epc));
         end
         tick();
      end
      // PC wrap at the top of the address space
      drive(0, 1, 2'd1, 32'hFFFF_FFFC, 32'h0, 1);
      chk("wrap_squash", instr_valid, 0);
      tick();
      drive(0, 0, 2'd0, 0, 0, 1);
      chk("wrap_bubble", instr_valid, 0);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      drive(0, 0, 2'd0, 0, 0, 1);
      chk("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
      chk("wrap_addr0", imem_addr, 32'h0);
      tick();
      drive(0, 0, 2'd0, 0, 0, 0);
      chk("wrap_valid", instr_valid, 1);
      chk("wrap_pc0", pc_out, 32'h0);
      tick();
      // reset while holding a stalled instruction in the skid
      drive(1, 0, 2'd0, 0, 0, 0);
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", pc_out, 32'h0);
      tick();
      drive(0, 0, 2'd0, 0, 0, 1);
      chk("rst_valid", instr_valid, 0);
      chk("rst_addr", imem_addr, 32'h0);
      tick();
      drive(0, 0, 2'd0, 0, 0, 1);
      chk("rst_restart_valid", instr_valid, 1);
      chk("rst_restart_pc", pc_out, 32'h0);
      tick();
      // randomized stream checked against program-order scoreboard
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      exp_pc = 32'h0; quiet = 0; prev_redir = 0; prev_stall = 0;
      for (int i = 0; i < 3000; i++) begin
         drive(1'b0, $urandom_range(0, 9) == 0, 2'($urandom),
               ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : $urandom) & 32'hFFFF_FFFC,
               $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 7);
         redir = resolve_valid & next_instr_sel[0];
         tgt = next_instr_sel[1] ? branch_target : jump_target;
         if (redir) chk("rnd_squash", instr_valid, 0);
         if (prev_redir) chk("rnd_redirect_bubble", instr_valid, 0);
         if (prev_stall && !redir) chk("rnd_stall_kept", instr_valid, 1);
         if (instr_valid) begin
            chk("rnd_pc", pc_out, exp_pc);
            chk("rnd_instr", instr_out, memf(pc_out));
         end
         if (redir || instr_valid) quiet = 0;
         else begin
            quiet++;
            chk("rnd_max_gap", 32'(quiet), quiet > 1 ? 32'd1 : 32'(quiet));
         end
         prev_stall = instr_valid & !instr_ready;
         prev_redir = redir;
         exp_pc = redir ? tgt : (instr_valid & instr_ready) ? exp_pc + 32'd4 : exp_pc;
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
